// File: rtl/data_memory_ws.sv
// data_memory_ws: single-port data memory behind a valid/ready request port.
// A request is latched on the accept edge, held for WAIT_CYCLES extra cycles and
// committed on the edge that enters RESP, which produces a one-cycle response.
// Stores honour byte enables; misaligned or out-of-range accesses return an error.
// Optional feature macro: DMEM_TOHOST_EN adds a sticky tohost completion register
// at TOHOST_ADDR. When it is undefined, tohost_done/tohost_val are tied to zero.
module data_memory_ws #(
  parameter int          DATA_W      = 32,
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_0FFC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [31:0]         req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy,
  output logic                tohost_done,
  output logic [DATA_W-1:0]   tohost_val
);

  localparam int          BE_W       = DATA_W / 8;
  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);
  // Only meaningful when WAIT_CYCLES > 0; the zero case bypasses WAIT entirely.
  localparam logic [3:0]  CNT_LOAD   = 4'(WAIT_CYCLES - 1);
`ifdef DMEM_TOHOST_EN
  localparam logic        TOHOST_EN  = 1'b1;
`else
  localparam logic        TOHOST_EN  = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [31:0]         addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                tohost_done_q, tohost_done_d;
  logic [DATA_W-1:0]   tohost_val_q, tohost_val_d;

  logic [DATA_W-1:0]   mem_q [DEPTH_WORDS];

  // Request view used at the commit edge: live inputs when committing straight
  // from IDLE (WAIT_CYCLES == 0), otherwise the fields latched at accept.
  logic                cur_we_s;
  logic [31:0]         cur_addr_s;
  logic [DATA_W-1:0]   cur_wdata_s;
  logic [BE_W-1:0]     cur_be_s;
  logic [AW-1:0]       cur_idx_s;
  logic                tohost_hit_s;
  logic                bad_addr_s;
  logic                err_s;
  logic                commit_s;
  logic                mem_we_s;

  // Next-state, address decode and response computation for the transaction FSM.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    be_d          = be_q;
    tohost_done_d = tohost_done_q;
    tohost_val_d  = tohost_val_q;

    if (state_q == ST_IDLE) begin
      cur_we_s    = req_we;
      cur_addr_s  = req_addr;
      cur_wdata_s = req_wdata;
      cur_be_s    = req_be;
    end else begin
      cur_we_s    = we_q;
      cur_addr_s  = addr_q;
      cur_wdata_s = wdata_q;
      cur_be_s    = be_q;
    end

    cur_idx_s    = cur_addr_s[AW+1:2];
    tohost_hit_s = TOHOST_EN && (cur_addr_s == TOHOST_ADDR);
    bad_addr_s   = (cur_addr_s[1:0] != 2'b00) || ({1'b0, cur_addr_s} >= ADDR_LIMIT);
    err_s        = bad_addr_s && !tohost_hit_s;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // RESP is always left after one cycle, so entering it is the commit edge.
    commit_s    = (state_d == ST_RESP);
    mem_we_s    = commit_s && cur_we_s && !err_s && !tohost_hit_s;
    rsp_valid_d = commit_s;
    rsp_err_d   = commit_s && err_s;

    if (commit_s && !cur_we_s && !err_s) begin
      if (tohost_hit_s) begin
        rsp_rdata_d = tohost_val_q;
      end else begin
        rsp_rdata_d = mem_q[cur_idx_s];
      end
    end else begin
      rsp_rdata_d = '0;
    end

    // Only the first full-word store to tohost is captured; later ones are acked and dropped.
    if (commit_s && cur_we_s && tohost_hit_s && (&cur_be_s) && !tohost_done_q) begin
      tohost_done_d = 1'b1;
      tohost_val_d  = cur_wdata_s;
    end else begin
      tohost_done_d = tohost_done_q;
      tohost_val_d  = tohost_val_q;
    end

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  // Control and output registers; reset wins over any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 4'd0;
      we_q          <= 1'b0;
      addr_q        <= 32'd0;
      wdata_q       <= '0;
      be_q          <= '0;
      ready_q       <= 1'b1;
      busy_q        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      tohost_done_q <= 1'b0;
      tohost_val_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      be_q          <= be_d;
      ready_q       <= ready_d;
      busy_q        <= busy_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      tohost_done_q <= tohost_done_d;
      tohost_val_q  <= tohost_val_d;
    end
  end

  // Byte-masked array write at the commit edge; suppressed when reset is high.
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst) begin
      for (int i = 0; i < BE_W; i++) begin
        if (cur_be_s[i]) begin
          mem_q[cur_idx_s][8*i +: 8] <= cur_wdata_s[8*i +: 8];
        end
      end
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
`ifdef DMEM_TOHOST_EN
  assign tohost_done = tohost_done_q;
  assign tohost_val  = tohost_val_q;
`else
  assign tohost_done = 1'b0;
  assign tohost_val  = '0;
`endif

endmodule

// File: tb/tb_data_memory_ws.sv
// Self-checking bench for data_memory_ws: one instance with WAIT_CYCLES=1 checked
// against a word-array reference model, plus a WAIT_CYCLES=3 instance for latency.
module tb_data_memory_ws;

`ifdef DMEM_TOHOST_EN
  localparam bit TB_TOHOST = 1'b1;
`else
  localparam bit TB_TOHOST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_valid3, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;

  logic        req_ready, rsp_valid, rsp_err, busy, tohost_done;
  logic [31:0] rsp_rdata, tohost_val;
  logic        req_ready3, rsp_valid3, rsp_err3, busy3, tohost_done3;
  logic [31:0] rsp_rdata3, tohost_val3;

  int checks   = 0;
  int failures = 0;

  // Reference model: plain word array plus tohost state.
  logic [31:0] model_mem [256];
  logic        model_done;
  logic [31:0] model_val;

  always #5 clk = ~clk;

  data_memory_ws #(.DATA_W(32), .DEPTH_WORDS(256), .WAIT_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .tohost_done(tohost_done), .tohost_val(tohost_val)
  );

  data_memory_ws #(.DATA_W(32), .DEPTH_WORDS(256), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3), .busy(busy3),
    .tohost_done(tohost_done3), .tohost_val(tohost_val3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic model_err(input logic [31:0] a);
    if (TB_TOHOST && a == 32'h0000_0FFC) return 1'b0;
    return (a[1:0] != 2'b00) || (a >= 32'd1024);
  endfunction

  // One transaction on the selected instance; returns response, latency in cycles
  // after the accept edge, and whether ready/busy/idle-zero rules held throughout.
  task automatic txn(input bit sel, input logic we, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] be,
                     output logic [31:0] rd, output logic er, output int lat, output bit ok);
    int  n;
    bit  found;
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    if (sel) req_valid3 = 1'b1; else req_valid = 1'b1;
    n = 0;
    while (!(sel ? req_ready3 : req_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_valid3 = 1'b0;
    req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    ok = 1'b1; found = 1'b0; lat = 0; rd = 32'hDEAD_BEEF; er = 1'bx;
    for (int c = 1; c <= 40 && !found; c++) begin
      @(negedge clk);
      if (sel ? rsp_valid3 : rsp_valid) begin
        found = 1'b1;
        lat   = c;
        rd    = sel ? rsp_rdata3 : rsp_rdata;
        er    = sel ? rsp_err3 : rsp_err;
        if ((sel ? req_ready3 : req_ready) || !(sel ? busy3 : busy)) ok = 1'b0;
      end else begin
        if ((sel ? rsp_rdata3 : rsp_rdata) != 32'd0 || (sel ? rsp_err3 : rsp_err) != 1'b0 ||
            (sel ? req_ready3 : req_ready) || !(sel ? busy3 : busy)) ok = 1'b0;
      end
    end
  endtask

  // Transaction on the WAIT_CYCLES=1 instance, checked against the model.
  task automatic do_op(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] rd, exp_rd;
    logic        er, exp_er, is_th;
    logic [7:0]  idx;
    int          lat;
    bit          ok;
    exp_er = model_err(addr);
    is_th  = TB_TOHOST && (addr == 32'h0000_0FFC);
    idx    = addr[9:2];
    exp_rd = 32'd0;
    if (!we && !exp_er) exp_rd = is_th ? model_val : model_mem[idx];
    txn(1'b0, we, addr, wd, be, rd, er, lat, ok);
    check({tag, "_lat"}, 32'(lat), 32'd2);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, {31'd0, er}, {31'd0, exp_er});
    check({tag, "_hs"}, {31'd0, ok}, 32'd1);
    if (we && !exp_er) begin
      if (is_th) begin
        if (be == 4'hF && !model_done) begin
          model_done = 1'b1;
          model_val  = wd;
        end
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) model_mem[idx][8*b +: 8] = wd[8*b +: 8];
        end
      end
    end
  endtask

  initial begin
    logic [31:0] rd, a;
    logic        er;
    int          lat, r;
    bit          ok, saw_rsp;

    rst = 1'b1; req_valid = 1'b0; req_valid3 = 1'b0;
    req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'd0;
    model_done = 1'b0; model_val = 32'd0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", {31'd0, rsp_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_th_done", {31'd0, tohost_done}, 32'd0);
    check("rst_th_val", tohost_val, 32'd0);
    check("rst_ready3", {31'd0, req_ready3}, 32'd1);

    // Request presented while reset is high must not be accepted.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd0;
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    check("rst_vs_valid_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("rst_vs_valid_rsp", {31'd0, rsp_valid}, 32'd0);

    // Preload every word so loads never see uninitialised storage.
    for (int i = 0; i < 256; i++) do_op("pre", 1'b1, 32'(i * 4), $urandom, 4'hF);

    // Store 15 to 0x0 then load it back.
    do_op("st0", 1'b1, 32'h0, 32'h0000_000F, 4'hF);
    txn(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat, ok);
    check("ld0_lat", 32'(lat), 32'd2);
    check("ld0_rdata", rd, 32'd15);
    check("ld0_err", {31'd0, er}, 32'd0);

    // Byte-enable merge.
    do_op("st4_full", 1'b1, 32'h4, 32'h1122_3344, 4'hF);
    do_op("st4_be", 1'b1, 32'h4, 32'hAABB_CCDD, 4'b0101);
    txn(1'b0, 1'b0, 32'h4, 32'h0, 4'h0, rd, er, lat, ok);
    check("ld4_rdata", rd, 32'h11BB_33DD);
    model_mem[1] = rd;
    do_op("st4_be0", 1'b1, 32'h4, 32'hFFFF_FFFF, 4'b0000);
    do_op("ld4_be0", 1'b0, 32'h4, 32'h0, 4'h0);

    // Error cases: misaligned load, out-of-range store aliasing word 0.
    do_op("ld_mis", 1'b0, 32'h6, 32'h0, 4'h0);
    do_op("st_oor", 1'b1, 32'h400, 32'h1234_5678, 4'hF);
    txn(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat, ok);
    check("oor_word0_kept", rd, 32'd15);

    // Tohost register.
`ifdef DMEM_TOHOST_EN
    do_op("th_st8", 1'b1, 32'h0000_0FFC, 32'd8, 4'hF);
    do_op("th_st9", 1'b1, 32'h0000_0FFC, 32'd9, 4'hF);
    check("th_done", {31'd0, tohost_done}, 32'd1);
    check("th_val", tohost_val, 32'd8);
    txn(1'b0, 1'b0, 32'h0000_0FFC, 32'h0, 4'h0, rd, er, lat, ok);
    check("th_ld", rd, 32'd8);
    check("th_ld_err", {31'd0, er}, 32'd0);
`else
    do_op("th_st_oor", 1'b1, 32'h0000_0FFC, 32'd8, 4'hF);
    check("th_done_tied", {31'd0, tohost_done}, 32'd0);
    check("th_val_tied", tohost_val, 32'd0);
`endif

    // Reset during WAIT: no response, no write, idle right after.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'hC; req_wdata = 32'h55; req_be = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_done = 1'b0; model_val = 32'd0;
    saw_rsp = 1'b0;
    @(negedge clk);
    check("rstmid_ready", {31'd0, req_ready}, 32'd1);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    if (rsp_valid) saw_rsp = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    check("rstmid_no_rsp", {31'd0, saw_rsp}, 32'd0);
    check("rstmid_th_done", {31'd0, tohost_done}, 32'd0);
    do_op("rstmid_ld", 1'b0, 32'hC, 32'h0, 4'h0);

    // Randomized mix against the model.
    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = {22'd0, 8'($urandom), 2'b00};
      else if (r == 7) a = {22'd0, 8'($urandom), 2'($urandom_range(1, 3))};
      else if (r == 8) a = 32'd1024 + (32'($urandom_range(0, 700)) << 2);
      else             a = {1'b1, 31'($urandom)};
      do_op("rnd", 1'($urandom), a, $urandom, 4'($urandom));
    end

    // WAIT_CYCLES=3 instance: latency and busy window.
    txn(1'b1, 1'b1, 32'h8, 32'hCAFE_0008, 4'hF, rd, er, lat, ok);
    check("w3_st_lat", 32'(lat), 32'd4);
    check("w3_st_rdata", rd, 32'd0);
    check("w3_st_hs", {31'd0, ok}, 32'd1);
    txn(1'b1, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, lat, ok);
    check("w3_ld_lat", 32'(lat), 32'd4);
    check("w3_ld_rdata", rd, 32'hCAFE_0008);
    check("w3_ld_err", {31'd0, er}, 32'd0);
    check("w3_ld_hs", {31'd0, ok}, 32'd1);
    @(negedge clk);
    check("w3_idle_ready", {31'd0, req_ready3}, 32'd1);
    check("w3_idle_busy", {31'd0, busy3}, 32'd0);
    txn(1'b1, 1'b0, 32'h6, 32'h0, 4'h0, rd, er, lat, ok);
    check("w3_mis_err", {31'd0, er}, 32'd1);
    check("w3_mis_rdata", rd, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
